// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the video pipeline. It produces the pixel
// coordinates and the active-area qualifier used by the overlay/text
// generators. It also produces line/frame strobes and hsync/vsync for the
// output pins. The sync outputs are delayed by SYNC_DELAY cycles so that they
// line up with the latency of the downstream pixel pipeline.
//
// Optional feature: define VGA_FRAME_COUNTER_EN to get a free-running 8-bit
// end-of-frame counter on frame_count. Without it, frame_count is tied to 0.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   x, y         raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   frame_active high inside the visible H_ACTIVE x V_ACTIVE area
//   line_start   one-cycle strobe at x==0
//   frame_start  one-cycle strobe at x==0, y==0
//   hsync, vsync sync pulses, SYNC_DELAY cycles late, SYNC_POL assertion level
//   frame_count  end-of-frame counter (0 unless VGA_FRAME_COUNTER_EN)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_active,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The 10-bit counters cannot cover larger rasters, and the delay line
    // supports at most three stages.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_param_check
        $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY in 0..3");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // The window bounds are 11 bits wide so that an H_ACTIVE/V_ACTIVE of
    // exactly 1024 still compares correctly against the 10-bit counters.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        SYNC_ACT  = (SYNC_POL != 0);

    logic        run;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        hs_raw;
    logic        vs_raw;
    logic        hs_dly;
    logic        vs_dly;

    // run lags reset release by one edge. That edge only arms the counters,
    // so the first counted cycle is a clean (0,0).
    // NOTE: every clocked block uses non-blocking assignments. All registers
    // then sample pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
            x   <= '0;
            y   <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (x == H_LAST) begin
                    x <= '0;
                    y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};

    // Decodes use the registered coordinates directly, so they line up with
    // x/y. They are gated by run, which holds them low in the idle cycle after
    // reset.
    // NOTE: each output is assigned on every path through the block, so no
    // latch is inferred.
    always_comb begin
        frame_active = run && (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
        line_start   = run && (x == 10'd0);
        frame_start  = run && (x == 10'd0) && (y == 10'd0);
        hs_raw       = run && (x_ext >= HS_FIRST) && (x_ext <= HS_LAST);
        vs_raw       = run && (y_ext >= VS_FIRST) && (y_ext <= VS_LAST);
    end

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hs_dly = hs_raw;
        assign vs_dly = vs_raw;
    end else begin : g_delay
        // pipe[0] holds the raw decode from one cycle ago and pipe[D-1] holds
        // it from D cycles ago. The stages freeze while run is low.
        logic [SYNC_DELAY-1:0] hs_pipe;
        logic [SYNC_DELAY-1:0] vs_pipe;
        logic [SYNC_DELAY:0]   hs_next;
        logic [SYNC_DELAY:0]   vs_next;

        assign hs_next = {hs_pipe, hs_raw};
        assign vs_next = {vs_pipe, vs_raw};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hs_pipe <= '0;
                vs_pipe <= '0;
            end else if (run) begin
                hs_pipe <= hs_next[SYNC_DELAY-1:0];
                vs_pipe <= vs_next[SYNC_DELAY-1:0];
            end
        end

        assign hs_dly = hs_pipe[SYNC_DELAY-1];
        assign vs_dly = vs_pipe[SYNC_DELAY-1];
    end

    // The pipeline carries active-high pulses. Polarity is applied only at
    // the pins, so the reset value of every stage means "inactive".
    assign hsync = SYNC_ACT ? hs_dly : ~hs_dly;
    assign vsync = SYNC_ACT ? vs_dly : ~vs_dly;

`ifdef VGA_FRAME_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (run && (x == H_LAST) && (y == V_LAST)) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Four instances run side by side:
//   u0: default timing, SYNC_DELAY=0            (line timing)
//   u1: 800-pixel lines, 8-line frames, delay 1 (frame timing, mid-frame reset)
//   u2: as u1, but SYNC_DELAY=2, SYNC_POL=1     (delayed, active-high sync)
//   u3: 12x7 raster, delay 1                    (256 frames, counter wrap)
// Frames are kept short so that frame-level behaviour is reachable within a
// few tens of thousands of cycles.
//
// The stimulus pushes hand-computed snapshots, each keyed to an absolute
// cycle. A monitor on the falling edge pops and compares every snapshot that
// falls due. Each snapshot can also carry running totals of active
// hsync/vsync/frame_active cycles since that instance left reset (-1 means
// the total is not checked).
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNTER_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    // Assertion level of the sync outputs, per instance (only u2 is active-high).
    localparam bit [3:0] ACT = 4'b0100;

    typedef struct {
        int    tick;
        string tag;
        int    x;
        int    y;
        bit    fa;
        bit    ls;
        bit    fs;
        bit    hs;
        bit    vs;
        int    fc;
        int    nhs;
        int    nvs;
        int    nfa;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rst_v;
    logic [9:0] x_s [4];
    logic [9:0] y_s [4];
    logic [3:0] fa_s, ls_s, fs_s, hs_s, vs_s;
    logic [7:0] fc_s [4];

    exp_t exp_q [4][$];
    int   tick = 0;
    int   base [4];
    bit   done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nhs [4];
    int   nvs [4];
    int   nfa [4];

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    vga_timing_gen #(.SYNC_DELAY(0)) u0 (
        .clk(clk), .rst_n(rst_v[0]), .x(x_s[0]), .y(y_s[0]),
        .frame_active(fa_s[0]), .line_start(ls_s[0]), .frame_start(fs_s[0]),
        .hsync(hs_s[0]), .vsync(vs_s[0]), .frame_count(fc_s[0]));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u1 (
        .clk(clk), .rst_n(rst_v[1]), .x(x_s[1]), .y(y_s[1]),
        .frame_active(fa_s[1]), .line_start(ls_s[1]), .frame_start(fs_s[1]),
        .hsync(hs_s[1]), .vsync(vs_s[1]), .frame_count(fc_s[1]));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .SYNC_POL(1), .SYNC_DELAY(2)) u2 (
        .clk(clk), .rst_n(rst_v[2]), .x(x_s[2]), .y(y_s[2]),
        .frame_active(fa_s[2]), .line_start(ls_s[2]), .frame_start(fs_s[2]),
        .hsync(hs_s[2]), .vsync(vs_s[2]), .frame_count(fc_s[2]));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u3 (
        .clk(clk), .rst_n(rst_v[3]), .x(x_s[3]), .y(y_s[3]),
        .frame_active(fa_s[3]), .line_start(ls_s[3]), .frame_start(fs_s[3]),
        .hsync(hs_s[3]), .vsync(vs_s[3]), .frame_count(fc_s[3]));

    // Queue a snapshot for instance i, k cycles after its current base.
    task automatic expect_at(input int i, input string tag, input int k,
                             input int ex, input int ey,
                             input bit fa, input bit ls, input bit fs,
                             input bit hs, input bit vs, input int fc,
                             input int cnt_hs = -1, input int cnt_vs = -1,
                             input int cnt_fa = -1);
        exp_t e;
        e.tick = base[i] + k;
        e.tag  = tag;
        e.x    = ex;
        e.y    = ey;
        e.fa   = fa;
        e.ls   = ls;
        e.fs   = fs;
        e.hs   = hs;
        e.vs   = vs;
        e.fc   = fc;
        e.nhs  = cnt_hs;
        e.nvs  = cnt_vs;
        e.nfa  = cnt_fa;
        exp_q[i].push_back(e);
    endtask

    initial begin
        rst_v = 4'h0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            base[i] = tick;
            expect_at(i, "in_reset", 0, 0, 0, 0, 0, 0, ~ACT[i], ~ACT[i], 0);
        end

        @(posedge clk);
        #1;
        rst_v = 4'hF;
        for (int i = 0; i < 4; i++) base[i] = tick;

        // u0: default 800x525 timing, no sync delay, active-low.
        expect_at(0, "release_idle",   0,   0, 0, 0, 0, 0, 1, 1, 0);
        expect_at(0, "first_active",   1,   0, 0, 1, 1, 1, 1, 1, 0);
        expect_at(0, "x_step",         2,   1, 0, 1, 0, 0, 1, 1, 0);
        expect_at(0, "last_visible",   640, 639, 0, 1, 0, 0, 1, 1, 0);
        expect_at(0, "active_end",     641, 640, 0, 0, 0, 0, 1, 1, 0);
        expect_at(0, "pre_hsync",      656, 655, 0, 0, 0, 0, 1, 1, 0);
        expect_at(0, "hsync_start",    657, 656, 0, 0, 0, 0, 0, 1, 0, 1);
        expect_at(0, "hsync_last",     752, 751, 0, 0, 0, 0, 0, 1, 0, 96);
        expect_at(0, "hsync_end",      753, 752, 0, 0, 0, 0, 1, 1, 0, 96);
        expect_at(0, "line_last",      800, 799, 0, 0, 0, 0, 1, 1, 0);
        expect_at(0, "line_wrap",      801, 0, 1, 1, 1, 0, 1, 1, 0, 96, 0, 641);

        // u1: 800x8 raster, delay 1, active-low; vsync raw on lines 5..6.
        expect_at(1, "release_idle",   0,     0, 0, 0, 0, 0, 1, 1, 0);
        expect_at(1, "first_active",   1,     0, 0, 1, 1, 1, 1, 1, 0);
        expect_at(1, "x_step",         2,     1, 0, 1, 0, 0, 1, 1, 0);
        expect_at(1, "hs_d1_pre",      657,   656, 0, 0, 0, 0, 1, 1, 0);
        expect_at(1, "hs_d1_start",    658,   657, 0, 0, 0, 0, 0, 1, 0, 1);
        expect_at(1, "vs_line",        4001,  0, 5, 0, 1, 0, 1, 1, 0);
        expect_at(1, "vsync_start",    4002,  1, 5, 0, 0, 0, 1, 0, 0, -1, 1);
        expect_at(1, "vsync_last",     5601,  0, 7, 0, 1, 0, 1, 0, 0, -1, 1600);
        expect_at(1, "vsync_end",      5602,  1, 7, 0, 0, 0, 1, 1, 0, -1, 1600);
        expect_at(1, "frame_last",     6400,  799, 7, 0, 0, 0, 1, 1, 0);
        expect_at(1, "frame_wrap",     6401,  0, 0, 1, 1, 1, 1, 1, FC_EN ? 1 : 0);
        expect_at(1, "after_wrap",     6402,  1, 0, 1, 0, 0, 1, 1, FC_EN ? 1 : 0);
        expect_at(1, "pre_reset",      10701, 300, 5, 0, 0, 0, 1, 0, FC_EN ? 1 : 0);
        expect_at(1, "reset_forced",   10702, 0, 0, 0, 0, 0, 1, 1, 0);

        // u2: 800x8 raster, delay 2, active-high.
        expect_at(2, "release_idle",   0,    0, 0, 0, 0, 0, 0, 0, 0);
        expect_at(2, "first_active",   1,    0, 0, 1, 1, 1, 0, 0, 0);
        expect_at(2, "hs_d2_pre",      658,  657, 0, 0, 0, 0, 0, 0, 0);
        expect_at(2, "hs_d2_start",    659,  658, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_at(2, "hs_d2_last",     754,  753, 0, 0, 0, 0, 1, 0, 0, 96);
        expect_at(2, "hs_d2_end",      755,  754, 0, 0, 0, 0, 0, 0, 0, 96);
        expect_at(2, "vs_d2_pre",      4002, 1, 5, 0, 0, 0, 0, 0, 0);
        expect_at(2, "vs_d2_start",    4003, 2, 5, 0, 0, 0, 0, 1, 0, -1, 1);
        expect_at(2, "vs_d2_last",     5602, 1, 7, 0, 0, 0, 0, 1, 0, -1, 1600);
        expect_at(2, "vs_d2_end",      5603, 2, 7, 0, 0, 0, 0, 0, 0, -1, 1600);

        // u3: 12x7 raster (84 cycles per frame), delay 1, active-low.
        expect_at(3, "release_idle",   0,     0, 0, 0, 0, 0, 1, 1, 0);
        expect_at(3, "first_active",   1,     0, 0, 1, 1, 1, 1, 1, 0);
        expect_at(3, "vs_small_start", 62,    1, 5, 0, 0, 0, 1, 0, 0, -1, 1);
        expect_at(3, "vs_small_last",  73,    0, 6, 0, 1, 0, 1, 0, 0, -1, 12);
        expect_at(3, "vs_small_end",   74,    1, 6, 0, 0, 0, 1, 1, 0, -1, 12);
        expect_at(3, "frame_last",     84,    11, 6, 0, 0, 0, 0, 1, 0, -1, -1, 32);
        expect_at(3, "frame_wrap",     85,    0, 0, 1, 1, 1, 1, 1, FC_EN ? 1 : 0);
        expect_at(3, "fc_255",         21421, 0, 0, 1, 1, 1, 1, 1, FC_EN ? 255 : 0);
        expect_at(3, "fc_pre_wrap",    21504, 11, 6, 0, 0, 0, 0, 1, FC_EN ? 255 : 0,
                  -1, -1, 8192);
        expect_at(3, "fc_wrap",        21505, 0, 0, 1, 1, 1, 1, 1, 0);

        // u1: assert reset while it shows (300,5), hold it, then release it.
        repeat (10701) @(posedge clk);
        #1;
        rst_v[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_v[1] = 1'b1;
        base[1]  = tick;
        expect_at(1, "rerelease_idle",  0,   0, 0, 0, 0, 0, 1, 1, 0);
        expect_at(1, "rerelease_first", 1,   0, 0, 1, 1, 1, 1, 1, 0);
        expect_at(1, "rerelease_step",  2,   1, 0, 1, 0, 0, 1, 1, 0);
        expect_at(1, "rerelease_wrap",  801, 0, 1, 1, 1, 0, 1, 1, 0, 96, 0, 641);

        while (tick < base[0] + 21510) @(posedge clk);
        done = 1'b1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_v[i]) begin
                nhs[i] = 0;
                nvs[i] = 0;
                nfa[i] = 0;
            end else begin
                if (hs_s[i] == ACT[i]) nhs[i] = nhs[i] + 1;
                if (vs_s[i] == ACT[i]) nvs[i] = nvs[i] + 1;
                if (fa_s[i])           nfa[i] = nfa[i] + 1;
            end

            while (exp_q[i].size() > 0 && exp_q[i][0].tick <= tick) begin
                exp_t e;
                bit   ok;
                e = exp_q[i].pop_front();
                checks = checks + 1;
                ok = (e.tick == tick)
                  && (int'(x_s[i]) == e.x) && (int'(y_s[i]) == e.y)
                  && (fa_s[i] === e.fa) && (ls_s[i] === e.ls) && (fs_s[i] === e.fs)
                  && (hs_s[i] === e.hs) && (vs_s[i] === e.vs)
                  && (int'(fc_s[i]) == e.fc)
                  && (e.nhs < 0 || nhs[i] == e.nhs)
                  && (e.nvs < 0 || nvs[i] == e.nvs)
                  && (e.nfa < 0 || nfa[i] == e.nfa);
                if (!ok) begin
                    errors = errors + 1;
                    $display("FAIL %s u%0d tick %0d (due %0d): got x=%0d y=%0d fa=%0b ls=%0b fs=%0b hs=%0b vs=%0b fc=%0d nhs=%0d nvs=%0d nfa=%0d; want x=%0d y=%0d fa=%0b ls=%0b fs=%0b hs=%0b vs=%0b fc=%0d nhs=%0d nvs=%0d nfa=%0d",
                             e.tag, i, tick, e.tick, x_s[i], y_s[i], fa_s[i], ls_s[i],
                             fs_s[i], hs_s[i], vs_s[i], fc_s[i], nhs[i], nvs[i], nfa[i],
                             e.x, e.y, e.fa, e.ls, e.fs, e.hs, e.vs, e.fc,
                             e.nhs, e.nvs, e.nfa);
                end
            end
        end

        if (done) begin
            for (int i = 0; i < 4; i++) begin
                while (exp_q[i].size() > 0) begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL %s u%0d: snapshot due at tick %0d never compared (run ended at %0d)",
                             e.tag, i, e.tick, tick);
                end
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
